instr_dispatch: RTL and testbench
=================================

Name: instr_dispatch

Overview:
- Fetch/dispatch front end of the microcontroller. Fetches 16-bit instructions from program ROM and presents them on `ir` to the per-opcode execute FSMs (MOV, ADD, ...).
- Consumes their `pc_inc`/`done` handshake, advances the PC and retires the instruction.
- Drives an idle word between instructions so every execute FSM returns to its start state.

Parameters:
- ADDR_W, 8, PC / ROM address width.
- RESET_PC, 0, PC value after reset.
- IDLE_IR, 16'hE000, word driven on `ir` outside EXEC; opcode 4'hE is reserved.
- IMPL_MASK, 16'h3FFF, bit k set means opcode k is implemented.
- TIMEOUT, 15, max EXEC cycles without `done`.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- rom_addr  out  ADDR_W  ROM address, equals pc.
- rom_req  out  1  fetch request.
- rom_data  in  16  instruction word.
- rom_valid  in  1  rom_data valid.
- ir  out  16  instruction to execute FSMs.
- exec_busy  out  1  high in EXEC.
- pc_inc  in  1  PC-increment request from execute FSM.
- done  in  1  instruction-complete pulse from execute FSM.
- pc  out  ADDR_W  program counter.
- halted  out  1  sticky halt.
- fault  out  1  sticky fault.
- fault_code  out  2  01 illegal opcode, 10 timeout.
- retired_cnt  out  16  retired instruction count.

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All state updates on rising clk.
- Reset values: state=BOOT, pc=RESET_PC, ir=IDLE_IR, rom_req=0, exec_busy=0, halted=0, fault=0, fault_code=00, retired_cnt=0, internal IR latch=IDLE_IR, inc_seen=0, timer=0.
- Reset mid-instruction abandons the instruction with no retire.
- BOOT: one cycle, rom_req=0, then FETCH.
- FETCH:
  - rom_req=1, rom_addr=pc.
  - On an edge with rom_valid=1, latch rom_data into IR and go to DECODE. Otherwise stay (unbounded wait).
- DECODE (1 cycle): op=IR[15:12].
  - op==4'hF: go to HALT.
  - IMPL_MASK[op]==1: go to EXEC, clear inc_seen and timer.
  - Otherwise: go to FAULT, fault_code=01.
- EXEC:
  - ir=IR latch; exec_busy=1.
  - Each cycle with pc_inc=1: pc<=pc+1 (mod 2^ADDR_W), inc_seen<=1.
  - done=1: go to RETIRE. A pc_inc in the same cycle is still honoured.
  - done held several cycles: only the first edge is acted on.
- RETIRE (1 cycle):
  - ir=IDLE_IR; retired_cnt<=retired_cnt+1 (wraps).
  - If inc_seen==0: pc<=pc+1.
  - Then FETCH.
- HALT: halted=1, rom_req=0, ir=IDLE_IR. pc holds the address of the halt word; not counted in retired_cnt. Sticky until rst.
- FAULT: fault=1, rom_req=0, ir=IDLE_IR. Sticky until rst.
- ir equals IDLE_IR in every state except EXEC.
- pc_inc and done are ignored outside EXEC.
- Minimum instruction time: FETCH 1 + DECODE 1 + EXEC 1 + RETIRE 1 = 4 cycles.
- pc wraps from 2^ADDR_W-1 to 0 with no flag.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- Defined:
  - timer counts EXEC cycles.
  - If TIMEOUT cycles elapse with done=0, go to FAULT with fault_code=10.
  - done on the same edge the limit is reached wins, so the instruction retires.
- Undefined: no timer; EXEC waits indefinitely; fault_code=10 never produced.

Test Plan:
- Reset, then release with rom_valid=1 → cycle 1 rom_req=0 (BOOT); cycle 2 rom_req=1, rom_addr=0x00.
- ROM[0]=0x6083 (MOV). Execute model pulses pc_inc in EXEC cycle 1 and done in EXEC cycle 3 → ir=0x6083 only while exec_busy=1, ir=0xE000 in RETIRE. Afterwards pc=0x01 (single increment), retired_cnt=1, next rom_addr=0x01.
- done with no pc_inc in EXEC → pc advances 0x01→0x02 in RETIRE.
- Two pc_inc pulses in EXEC, one of them coincident with done → pc advances by exactly 2.
- ROM[2]=0xE123 → fault=1, fault_code=01, rom_req=0 held for 20 cycles, pc=0x02.
- DISPATCH_TIMEOUT_EN defined, done never asserted → fault_code=10 exactly 15 EXEC cycles after entry. Separately:
  - ROM[3]=0xF000 → halted=1, pc=0x03, retired_cnt unchanged.
  - RESET_PC=0xFF with a pc_inc instruction → pc wraps to 0x00.

Source files
------------

// File: rtl/instr_dispatch_if.sv
// ---------------------------------------------------------------------------
// instr_dispatch_if
// Bundle of the fetch/dispatch front end's bus signals.
//   ROM side     : rom_addr, rom_req (to ROM); rom_data, rom_valid (from ROM)
//   Execute side : ir, exec_busy (to execute FSMs); pc_inc, done (from them)
// Modports:
//   master - the dispatch unit (instr_dispatch)
//   slave  - the program ROM plus the per-opcode execute FSMs
// ---------------------------------------------------------------------------
interface instr_dispatch_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_req;
  logic [15:0]       rom_data;
  logic              rom_valid;
  logic [15:0]       ir;
  logic              exec_busy;
  logic              pc_inc;
  logic              done;

  modport master (
    output rom_addr, rom_req, ir, exec_busy,
    input  rom_data, rom_valid, pc_inc, done
  );

  modport slave (
    input  rom_addr, rom_req, ir, exec_busy,
    output rom_data, rom_valid, pc_inc, done
  );
endinterface

// File: rtl/instr_dispatch.sv
// ---------------------------------------------------------------------------
// instr_dispatch
// Fetch/dispatch front end of the microcontroller. Fetches 16-bit words from
// program ROM, decodes the opcode, presents the instruction on ir to the
// per-opcode execute FSMs, consumes their pc_inc/done handshake, advances the
// PC and retires the instruction. Outside EXEC an idle word is driven on ir so
// every execute FSM falls back to its start state.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus          instr_dispatch_if.master (rom_addr/rom_req/rom_data/rom_valid,
//                ir/exec_busy/pc_inc/done)
//   pc           program counter (rom_addr mirrors it)
//   halted       sticky, set by opcode 4'hF
//   fault        sticky, illegal opcode or execute timeout
//   fault_code   01 illegal opcode, 10 timeout
//   retired_cnt  retired instruction count (wraps)
//
// Optional feature, macro DISPATCH_TIMEOUT_EN:
//   defined   - an EXEC watchdog faults with code 10 after TIMEOUT cycles
//               without done (TIMEOUT parameter exists only in this build)
//   undefined - EXEC waits for done indefinitely
// ---------------------------------------------------------------------------
module instr_dispatch #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]       IDLE_IR   = 16'hE000,
  parameter logic [15:0]       IMPL_MASK = 16'h3FFF
`ifdef DISPATCH_TIMEOUT_EN
  ,
  parameter int                TIMEOUT   = 15
`endif
) (
  input  logic               clk,
  input  logic               rst,
  instr_dispatch_if.master   bus,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [15:0]        retired_cnt
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_RETIRE,
    S_HALT,
    S_FAULT
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [15:0]       ir_q;
  logic [15:0]       ir_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic              inc_seen;
  logic              inc_seen_nx;
  logic [15:0]       cnt_nx;
  logic [1:0]        code_nx;
  logic [3:0]        op;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nx;
`endif

  assign op = ir_q[15:12];

  // Outputs are decoded straight from the registered state so they are
  // glitch-free and never depend combinationally on the handshake inputs.
  assign bus.rom_addr  = pc;
  assign bus.rom_req   = (state == S_FETCH);
  assign bus.exec_busy = (state == S_EXEC);
  assign bus.ir        = (state == S_EXEC) ? ir_q : IDLE_IR;
  assign halted        = (state == S_HALT);
  assign fault         = (state == S_FAULT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      ir_q        <= IDLE_IR;
      inc_seen    <= 1'b0;
      retired_cnt <= '0;
      fault_code  <= 2'b00;
`ifdef DISPATCH_TIMEOUT_EN
      timer       <= '0;
`endif
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      ir_q        <= ir_nx;
      inc_seen    <= inc_seen_nx;
      retired_cnt <= cnt_nx;
      fault_code  <= code_nx;
`ifdef DISPATCH_TIMEOUT_EN
      timer       <= timer_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    ir_nx       = ir_q;
    inc_seen_nx = inc_seen;
    cnt_nx      = retired_cnt;
    code_nx     = fault_code;
`ifdef DISPATCH_TIMEOUT_EN
    timer_nx    = timer;
`endif

    case (state)
      S_BOOT: state_nx = S_FETCH;

      S_FETCH: begin
        if (bus.rom_valid) begin
          ir_nx    = bus.rom_data;
          state_nx = S_DECODE;
        end
      end

      S_DECODE: begin
        if (op == 4'hF) begin
          state_nx = S_HALT;
        end else if (IMPL_MASK[op]) begin
          state_nx    = S_EXEC;
          inc_seen_nx = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
          timer_nx    = '0;
`endif
        end else begin
          state_nx = S_FAULT;
          code_nx  = 2'b01;
        end
      end

      S_EXEC: begin
        // pc_inc is honoured even on the cycle that done arrives.
        if (bus.pc_inc) begin
          pc_nx       = pc + 1'b1;
          inc_seen_nx = 1'b1;
        end
        // done on the same edge as the watchdog limit wins.
        if (bus.done) begin
          state_nx = S_RETIRE;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (timer == TIMER_LAST) begin
          state_nx = S_FAULT;
          code_nx  = 2'b10;
        end else begin
          timer_nx = timer + 1'b1;
        end
`endif
      end

      S_RETIRE: begin
        cnt_nx = retired_cnt + 16'd1;
        // Instructions that never requested an increment still step the PC.
        if (!inc_seen) begin
          pc_nx = pc + 1'b1;
        end
        state_nx = S_FETCH;
      end

      S_HALT:  state_nx = S_HALT;
      S_FAULT: state_nx = S_FAULT;

      default: state_nx = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_instr_dispatch.sv
// ---------------------------------------------------------------------------
// tb_instr_dispatch
// Self-checking bench for instr_dispatch. The bench plays both the program ROM
// (random rom_valid latency) and the execute FSM (random pc_inc/done plans),
// and keeps an instruction-level reference model: the expected PC and retire
// count after each instruction, derived from how many pc_inc pulses were
// issued, plus the expected halt/fault outcome from the opcode.
// ---------------------------------------------------------------------------
module tb_instr_dispatch;

  localparam int          ADDR_W  = 8;
  localparam logic [15:0] IDLE_IR = 16'hE000;
  localparam int          TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              fault;
  logic [1:0]        fault_code;
  logic [15:0]       retired_cnt;

  logic [15:0] rom [256];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;

  instr_dispatch_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.rom_data = rom[bus.rom_addr];

  instr_dispatch #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault),
    .fault_code  (fault_code),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Junk on every input the DUT should currently be ignoring.
  task automatic idleInputs();
    bus.rom_valid = 1'($urandom_range(0, 1));
    bus.pc_inc    = 1'($urandom_range(0, 1));
    bus.done      = 1'($urandom_range(0, 1));
  endtask

  // Opcodes 0..13 are implemented, 14 is reserved, 15 halts.
  function automatic bit isLegal(input logic [3:0] op);
    return op <= 4'd13;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
    #1;
    checkOutput("rst_ir", bus.ir, IDLE_IR);
    checkOutput("rst_rom_req", bus.rom_req, 1'b0);
    checkOutput("rst_exec_busy", bus.exec_busy, 1'b0);
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_fault", fault, 1'b0);
    checkOutput("rst_fault_code", fault_code, 2'b00);
    checkOutput("rst_retired_cnt", retired_cnt, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("boot_rom_req", bus.rom_req, 1'b0);
    m_pc  = 8'h00;
    m_cnt = 16'h0000;
    @(negedge clk);
  endtask

  // Runs one instruction from the current model PC. Called at a negedge.
  // exec_len = cycles in EXEC with done on the last; 0 = never assert done
  // (timeout build faults, default build gives done after a long wait).
  // outcome: 0 retired, 1 halted, 2 faulted.
  task automatic applyStimulus(input int exec_len, input logic [15:0] inc_mask,
                               output int outcome);
    int          waited;
    int          tries;
    int          n_inc;
    int          len;
    bit          v;
    logic [15:0] word;
    logic [3:0]  op;

    outcome = -1;
    waited  = 0;
    while (bus.rom_req !== 1'b1 && waited < 20) begin
      idleInputs();
      @(negedge clk);
      waited++;
    end
    checkOutput("fetch_req", bus.rom_req, 1'b1);
    checkOutput("fetch_addr", bus.rom_addr, m_pc);
    checkOutput("fetch_pc", pc, m_pc);
    checkOutput("fetch_cnt", retired_cnt, m_cnt);
    checkOutput("fetch_ir_idle", bus.ir, IDLE_IR);
    word = rom[m_pc];
    op   = word[15:12];

    tries = 0;
    do begin
      v = (tries >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.rom_valid = v;
      bus.pc_inc    = 1'($urandom_range(0, 1));
      bus.done      = 1'($urandom_range(0, 1));
      @(negedge clk);
      tries++;
      if (!v) checkOutput("fetch_hold", bus.rom_req, 1'b1);
    end while (!v);

    checkOutput("decode_req", bus.rom_req, 1'b0);
    checkOutput("decode_ir", bus.ir, IDLE_IR);
    checkOutput("decode_busy", bus.exec_busy, 1'b0);
    idleInputs();
    @(negedge clk);

    if (op == 4'hF) begin
      checkOutput("halt_halted", halted, 1'b1);
      checkOutput("halt_fault", fault, 1'b0);
      checkOutput("halt_pc", pc, m_pc);
      checkOutput("halt_cnt", retired_cnt, m_cnt);
      checkOutput("halt_req", bus.rom_req, 1'b0);
      outcome = 1;
    end else if (!isLegal(op)) begin
      checkOutput("illegal_fault", fault, 1'b1);
      checkOutput("illegal_code", fault_code, 2'b01);
      checkOutput("illegal_pc", pc, m_pc);
      checkOutput("illegal_req", bus.rom_req, 1'b0);
      outcome = 2;
    end else begin
`ifdef DISPATCH_TIMEOUT_EN
      len = (exec_len == 0) ? TIMEOUT : exec_len;
`else
      len = (exec_len == 0) ? 40 : exec_len;
`endif
      n_inc = 0;
      for (int k = 0; k < len; k++) begin
        checkOutput("exec_busy", bus.exec_busy, 1'b1);
        checkOutput("exec_ir", bus.ir, word);
        bus.pc_inc    = (k < 16) ? inc_mask[k] : 1'b0;
        bus.rom_valid = 1'($urandom_range(0, 1));
`ifdef DISPATCH_TIMEOUT_EN
        bus.done      = (exec_len != 0) && (k == len - 1);
`else
        bus.done      = (k == len - 1);
`endif
        if (bus.pc_inc) n_inc++;
        @(negedge clk);
      end
`ifdef DISPATCH_TIMEOUT_EN
      if (exec_len == 0) begin
        checkOutput("timeout_fault", fault, 1'b1);
        checkOutput("timeout_code", fault_code, 2'b10);
        checkOutput("timeout_busy", bus.exec_busy, 1'b0);
        checkOutput("timeout_cnt", retired_cnt, m_cnt);
        outcome = 2;
        return;
      end
`endif
      checkOutput("retire_busy", bus.exec_busy, 1'b0);
      checkOutput("retire_ir", bus.ir, IDLE_IR);
      checkOutput("retire_req", bus.rom_req, 1'b0);
      m_pc  = m_pc + ((n_inc == 0) ? 8'd1 : 8'(n_inc));
      m_cnt = m_cnt + 16'd1;
      // done held past its first edge must not be acted on again.
      bus.done   = 1'b1;
      bus.pc_inc = 1'($urandom_range(0, 1));
      @(negedge clk);
      outcome = 0;
    end
  endtask

  initial begin
    #2ms;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    int outcome;

    rst           = 1'b1;
    bus.rom_valid = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.done      = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

    // MOV with one increment, then a no-increment instruction, then reserved opcode.
    $display("[TB] directed: retire and illegal opcode");
    rom[0] = 16'h6083;
    rom[1] = 16'h1234;
    rom[2] = 16'hE123;
    applyReset();
    applyStimulus(3, 16'b001, outcome);
    checkOutput("mov_outcome", outcome, 0);
    applyStimulus(2, 16'b000, outcome);
    checkOutput("noinc_outcome", outcome, 0);
    applyStimulus(1, 16'b000, outcome);
    checkOutput("illegal_outcome", outcome, 2);
    for (int i = 0; i < 20; i++) begin
      idleInputs();
      @(negedge clk);
      checkOutput("fault_sticky", fault, 1'b1);
      checkOutput("fault_sticky_code", fault_code, 2'b01);
      checkOutput("fault_sticky_req", bus.rom_req, 1'b0);
      checkOutput("fault_sticky_pc", pc, 8'h02);
      checkOutput("fault_sticky_ir", bus.ir, IDLE_IR);
    end

    // Two increments, one coincident with done, then a plain one, then halt.
    $display("[TB] directed: double increment and halt");
    rom[0] = 16'h3001;
    rom[2] = 16'h0000;
    rom[3] = 16'hF000;
    applyReset();
    applyStimulus(3, 16'b110, outcome);
    checkOutput("dbl_outcome", outcome, 0);
    applyStimulus(1, 16'b000, outcome);
    applyStimulus(1, 16'b000, outcome);
    checkOutput("halt_outcome", outcome, 1);
    for (int i = 0; i < 10; i++) begin
      idleInputs();
      @(negedge clk);
      checkOutput("halt_sticky", halted, 1'b1);
      checkOutput("halt_sticky_pc", pc, 8'h03);
      checkOutput("halt_sticky_cnt", retired_cnt, 16'd2);
      checkOutput("halt_sticky_req", bus.rom_req, 1'b0);
    end

    // Execute FSM that is slow or never answers.
    $display("[TB] directed: long execute");
    rom[0] = 16'h5000;
    rom[1] = 16'h5000;
    applyReset();
`ifdef DISPATCH_TIMEOUT_EN
    applyStimulus(TIMEOUT, 16'h0001, outcome);
    checkOutput("limit_done_outcome", outcome, 0);
    applyStimulus(0, 16'h0000, outcome);
    checkOutput("timeout_outcome", outcome, 2);
`else
    applyStimulus(0, 16'h0000, outcome);
    checkOutput("long_wait_outcome", outcome, 0);
    checkOutput("long_wait_fault", fault, 1'b0);
`endif

    // Reset in the middle of an instruction abandons it.
    $display("[TB] directed: reset mid-instruction");
    rom[0] = 16'h7000;
    applyReset();
    bus.rom_valid = 1'b1;
    bus.pc_inc    = 1'b0;
    bus.done      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_busy", bus.exec_busy, 1'b1);
    bus.pc_inc = 1'b1;
    @(negedge clk);
    checkOutput("mid_pc", pc, 8'h01);
    applyReset();

    // Random program of implemented opcodes; long enough for pc to wrap.
    $display("[TB] random program");
    for (int i = 0; i < 256; i++) begin
      rom[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
    end
    applyReset();
    for (int n = 0; n < 320; n++) begin
      applyStimulus($urandom_range(1, 5), 16'($urandom), outcome);
      checkOutput("rand_outcome", outcome, 0);
    end
    applyStimulus(1, 16'h0000, outcome);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
